rf_wb_sched: RTL and testbench

Write-back scheduler and scoreboard for the single-write-port register file.
- Shares the one RF write port (RFWr/A3/WD) among NREQ result producers (ALU, load unit, multiplier, ...) using round-robin arbitration.
- Tracks destination registers with an in-flight result and stalls issue on RAW/WAW hazards.
- Sits between the issue stage, the execution units and the RF.

---
 rtl/rf_wb_sched.sv | 102 ++++++++++
 tb/tb_rf_wb_sched.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_sched.sv
// Write-back scheduler for the single-write-port register file: round-robin
// arbitration among result producers plus a pending-write scoreboard for issue hazards.
module rf_wb_sched #(
  parameter int NREQ = 2,
  parameter int DW   = 32,
  parameter int AW   = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               issue_vld,
  input  logic [AW-1:0]      issue_rd,
  input  logic [AW-1:0]      issue_rs1,
  input  logic [AW-1:0]      issue_rs2,
  output logic               issue_stall,
  input  logic [NREQ-1:0]    req_vld,
  input  logic [NREQ*AW-1:0] req_rd,
  input  logic [NREQ*DW-1:0] req_wd,
  output logic [NREQ-1:0]    req_rdy,
  output logic               RFWr,
  output logic [AW-1:0]      A3,
  output logic [DW-1:0]      WD,
  output logic [31:0]        busy_mask,
  output logic               wb_err
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0] rrPtr_q, rrPtr_d;
  logic [PW-1:0] gntIdx, scanIdx;
  logic          gntVld;
  logic [AW-1:0] gntRd;
  logic [DW-1:0] gntWd;
  logic [31:0]   pend_q, pend_d;
  logic          rfWr_q;
  logic [AW-1:0] a3_q;
  logic [DW-1:0] wd_q;
  logic          wbErr_q, wbErr_d;
  logic          hitRs1, hitRs2, hitRd, issueOk, gntHasRd;

  // Scan starts at the round-robin pointer so the last winner has lowest priority.
  always_comb begin
    req_rdy = '0;
    gntIdx  = '0;
    gntVld  = 1'b0;
    scanIdx = '0;
    for (int k = 0; k < NREQ; k++) begin
      scanIdx = PW'((int'(rrPtr_q) + k) % NREQ);
      if (!gntVld && req_vld[scanIdx]) begin
        gntVld = 1'b1;
        gntIdx = scanIdx;
      end
    end
    if (gntVld) req_rdy[gntIdx] = 1'b1;
  end

  assign gntRd    = req_rd[int'(gntIdx)*AW +: AW];
  assign gntWd    = req_wd[int'(gntIdx)*DW +: DW];
  assign gntHasRd = gntVld && (gntRd != '0);

  assign hitRs1      = (issue_rs1 != '0) && pend_q[issue_rs1];
  assign hitRs2      = (issue_rs2 != '0) && pend_q[issue_rs2];
  assign hitRd       = (issue_rd  != '0) && pend_q[issue_rd];
  assign issue_stall = issue_vld && (hitRs1 || hitRs2 || hitRd);
  assign issueOk     = issue_vld && !issue_stall;

  // Clear before set so a same-cycle set on the same register wins.
  always_comb begin
    pend_d = pend_q;
    if (gntHasRd) pend_d[gntRd] = 1'b0;
    if (issueOk && (issue_rd != '0)) pend_d[issue_rd] = 1'b1;
    pend_d[0] = 1'b0;
    wbErr_d = wbErr_q || (gntHasRd && !pend_q[gntRd]);
    rrPtr_d = gntVld ? PW'((int'(gntIdx) + 1) % NREQ) : rrPtr_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q  <= '0;
      rrPtr_q <= '0;
      rfWr_q  <= 1'b0;
      a3_q    <= '0;
      wd_q    <= '0;
      wbErr_q <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      rrPtr_q <= rrPtr_d;
      wbErr_q <= wbErr_d;
      rfWr_q  <= gntHasRd;
      if (gntVld) begin
        a3_q <= gntRd;
        wd_q <= gntWd;
      end
    end
  end

  assign RFWr      = rfWr_q;
  assign A3        = a3_q;
  assign WD        = wd_q;
  assign busy_mask = pend_q;
  assign wb_err    = wbErr_q;

endmodule

// File: tb/tb_rf_wb_sched.sv
// Randomized scoreboard bench for rf_wb_sched: a register-level reference model predicts
// grants, stalls and RF writes; a posedge monitor matches RF writes against expected ones.
module tb_rf_wb_sched;
  localparam int NREQ = 2;
  localparam int DW   = 32;
  localparam int AW   = 5;

  typedef struct {
    logic [AW-1:0] rd;
    logic [DW-1:0] wd;
  } wbT;

  logic               clk = 1'b0;
  logic               rst;
  logic               issue_vld;
  logic [AW-1:0]      issue_rd, issue_rs1, issue_rs2;
  logic               issue_stall;
  logic [NREQ-1:0]    req_vld;
  logic [NREQ*AW-1:0] req_rd;
  logic [NREQ*DW-1:0] req_wd;
  logic [NREQ-1:0]    req_rdy;
  logic               RFWr;
  logic [AW-1:0]      A3;
  logic [DW-1:0]      WD;
  logic [31:0]        busy_mask;
  logic               wb_err;

  int checks = 0;
  int failures = 0;

  bit            mPend[32];
  int            mPtr;
  bit            mErr;
  wbT            expQ[$];

  bit            jobVld[NREQ];
  logic [AW-1:0] jobRd[NREQ];
  logic [DW-1:0] jobWd[NREQ];
  bit            iVld;
  logic [AW-1:0] iRd, iRs1, iRs2;

  rf_wb_sched #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .issue_vld(issue_vld), .issue_rd(issue_rd), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_stall(issue_stall),
    .req_vld(req_vld), .req_rd(req_rd), .req_wd(req_wd), .req_rdy(req_rdy),
    .RFWr(RFWr), .A3(A3), .WD(WD), .busy_mask(busy_mask), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] packPend();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = mPend[i];
    return v;
  endfunction

  function automatic bit isBusy(input logic [AW-1:0] r);
    return (r != '0) && mPend[r];
  endfunction

  task automatic setIssue(input bit v, input int rd, input int rs1, input int rs2);
    iVld = v;
    iRd  = AW'(rd);
    iRs1 = AW'(rs1);
    iRs2 = AW'(rs2);
  endtask

  task automatic setJob(input int i, input int rd, input logic [DW-1:0] wd);
    jobVld[i] = 1'b1;
    jobRd[i]  = AW'(rd);
    jobWd[i]  = wd;
  endtask

  task automatic clearModel();
    for (int i = 0; i < 32; i++) mPend[i] = 1'b0;
    mPtr = 0;
    mErr = 1'b0;
    expQ.delete();
    for (int i = 0; i < NREQ; i++) jobVld[i] = 1'b0;
    iVld = 1'b0;
  endtask

  task automatic driveInputs();
    issue_vld = iVld;
    issue_rd  = iRd;
    issue_rs1 = iRs1;
    issue_rs2 = iRs2;
    for (int i = 0; i < NREQ; i++) begin
      req_vld[i]           = jobVld[i];
      req_rd[i*AW +: AW]   = jobRd[i];
      req_wd[i*DW +: DW]   = jobWd[i];
    end
  endtask

  // One cycle: check registered state, drive, check combinational outputs, advance the model.
  task automatic applyStimulus();
    int g;
    bit expStall;
    logic [NREQ-1:0] expRdy;
    logic [AW-1:0] r;
    @(negedge clk);
    #1;
    checkOutput("busy_mask", busy_mask, packPend());
    checkOutput("wb_err", {31'b0, wb_err}, {31'b0, mErr});
    driveInputs();
    #1;
    expStall = iVld && (isBusy(iRs1) || isBusy(iRs2) || isBusy(iRd));
    g = -1;
    for (int k = 0; k < NREQ; k++) begin
      if (g < 0 && jobVld[(mPtr + k) % NREQ]) g = (mPtr + k) % NREQ;
    end
    expRdy = '0;
    if (g >= 0) expRdy[g] = 1'b1;
    checkOutput("issue_stall", {31'b0, issue_stall}, {31'b0, expStall});
    checkOutput("req_rdy", 32'(req_rdy), 32'(expRdy));
    if (g >= 0) begin
      r = jobRd[g];
      if (r != '0) begin
        if (!mPend[r]) mErr = 1'b1;
        mPend[r] = 1'b0;
        expQ.push_back('{rd: r, wd: jobWd[g]});
      end
      mPtr = (g + 1) % NREQ;
      jobVld[g] = 1'b0;
    end
    if (iVld && !expStall && iRd != '0) mPend[iRd] = 1'b1;
  endtask

  // RF writes appear one cycle after the grant that produced them.
  initial begin
    wbT e;
    forever begin
      @(posedge clk);
      #1;
      if (rst === 1'b1) begin
        if (RFWr === 1'b1) begin
          if (expQ.size() == 0) begin
            checkOutput("unexpected RFWr", 32'd1, 32'd0);
          end else begin
            e = expQ.pop_front();
            checkOutput("A3", 32'(A3), 32'(e.rd));
            checkOutput("WD", WD, e.wd);
          end
        end else if (expQ.size() != 0) begin
          e = expQ.pop_front();
          checkOutput("missing RFWr", 32'(RFWr), 32'd1);
        end
      end
    end
  end

  initial begin
    int n0, n1;
    int pl[$];
    rst = 1'b0;
    clearModel();
    setIssue(0, 0, 0, 0);
    for (int i = 0; i < NREQ; i++) begin
      jobRd[i] = '0;
      jobWd[i] = '0;
    end
    driveInputs();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset RFWr", 32'(RFWr), 32'd0);
    checkOutput("reset A3", 32'(A3), 32'd0);
    checkOutput("reset WD", WD, 32'd0);
    checkOutput("reset busy_mask", busy_mask, 32'd0);
    checkOutput("reset wb_err", 32'(wb_err), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Basic RAW: x5 in flight stalls a reader until requester 0 writes it back.
    setIssue(1, 5, 0, 0); applyStimulus();
    setIssue(1, 6, 5, 0); applyStimulus();
    setIssue(1, 6, 5, 0); setJob(0, 5, 32'hDEADBEEF); applyStimulus();
    setIssue(1, 6, 5, 0); applyStimulus();

    // Write-back to x0 is consumed silently.
    setIssue(0, 0, 0, 0); setJob(0, 0, 32'h1234_5678); applyStimulus();
    applyStimulus();

    // Both requesters back-to-back on pending registers.
    for (int r = 0; r < 4; r++) begin
      setIssue(1, (r < 2) ? 3 + r : 10 + r - 2, 0, 0);
      applyStimulus();
    end
    setIssue(0, 0, 0, 0);
    n0 = 0; n1 = 0;
    for (int c = 0; c < 4; c++) begin
      if (!jobVld[0] && n0 < 2) begin setJob(0, (n0 == 0) ? 3 : 10, $urandom); n0++; end
      if (!jobVld[1] && n1 < 2) begin setJob(1, (n1 == 0) ? 4 : 11, $urandom); n1++; end
      applyStimulus();
    end
    applyStimulus();

    // Write-back to a register nobody is waiting on.
    setJob(0, 7, 32'hCAFE_0007); applyStimulus();
    applyStimulus();
    applyStimulus();

    // WAW on x9 with the clearing grant in the stalled cycle.
    setIssue(1, 9, 0, 0); applyStimulus();
    setIssue(1, 9, 0, 0); setJob(1, 9, 32'h0000_0009); applyStimulus();
    setIssue(1, 9, 0, 0); applyStimulus();
    setIssue(0, 0, 0, 0); applyStimulus();
    applyStimulus();

    // Random traffic; requesters hold their job until granted.
    for (int c = 0; c < 400; c++) begin
      setIssue($urandom % 2, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
      pl.delete();
      for (int i = 1; i < 32; i++) if (mPend[i]) pl.push_back(i);
      for (int i = 0; i < NREQ; i++) begin
        if (!jobVld[i] && ($urandom % 100) < 40) begin
          if (pl.size() != 0 && ($urandom % 100) < 70)
            setJob(i, pl[$urandom_range(0, pl.size() - 1)], $urandom);
          else
            setJob(i, $urandom_range(0, 15), $urandom);
        end
      end
      applyStimulus();
    end

    // Asynchronous reset while a write is on the RF port.
    setIssue(0, 0, 0, 0);
    for (int i = 0; i < NREQ; i++) jobVld[i] = 1'b0;
    applyStimulus();
    applyStimulus();
    setJob(0, 12, 32'hA5A5_0012); applyStimulus();
    @(negedge clk);
    #1;
    checkOutput("RFWr before reset", 32'(RFWr), 32'd1);
    rst = 1'b0;
    #1;
    checkOutput("async reset RFWr", 32'(RFWr), 32'd0);
    checkOutput("async reset A3", 32'(A3), 32'd0);
    checkOutput("async reset WD", WD, 32'd0);
    checkOutput("async reset busy_mask", busy_mask, 32'd0);
    clearModel();
    driveInputs();
    @(negedge clk);
    rst = 1'b1;
    setJob(0, 1, 32'h1111_1111); setJob(1, 2, 32'h2222_2222); applyStimulus();
    applyStimulus();
    applyStimulus();

    @(posedge clk);
    #2;
    checkOutput("expected writes drained", expQ.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
